// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetchState_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry prefetch FIFO with push/pop/flush; full and empty derive from the occupancy count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  fetchEntry_t pushEntry,
  output fetchEntry_t headEntry,
  output logic        full,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  fetchEntry_t      mem [DEPTH];
  logic [PW-1:0]    headPtr;
  logic [PW-1:0]    tailPtr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PW'(1);
      if (pop)  headPtr <= headPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[tailPtr] <= pushEntry;
  end

  assign headEntry = mem[headPtr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, BOOT/RUN FSM, prefetch queue and branch redirect.
// Optional macro FETCH_PERF_EN enables the perf_fetched push counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic [31:0] perf_fetched
);

  fetchState_t state;
  fetchState_t nextState;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  fetchEntry_t pushEntry;
  fetchEntry_t headEntry;

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      BOOT:    nextState = RUN;
      RUN:     nextState = RUN;
      default: nextState = BOOT;
    endcase
  end

  assign pcPlus4   = pc + PC_STEP;
  assign pop       = out_valid & out_ready;
  assign push      = (state == RUN) & ~redirect & (~full | pop);
  assign pushEntry = '{instr: imem_data, pc4: pcPlus4};

  // Redirect outranks push, and also applies while still in BOOT.
  always_ff @(posedge clk) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= {redirect_pc[31:2], 2'b00};
    else if (push)     pc <= pcPlus4;
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) uQueue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .pushEntry (pushEntry),
    .headEntry (headEntry),
    .full      (full),
    .empty     (empty)
  );

  assign imem_addr = pc;
  assign out_valid = ~empty;
  assign out_instr = empty ? NOP_INSTR : headEntry.instr;
  assign out_pc4   = empty ? NOP_INSTR : headEntry.pc4;

`ifdef FETCH_PERF_EN
  logic [31:0] perfCount;

  always_ff @(posedge clk) begin
    if (reset)     perfCount <= '0;
    else if (push) perfCount <= perfCount + 32'd1;
  end

  assign perf_fetched = perfCount;
`else
  assign perf_fetched = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (default and wrap-around RESET_PC instances).
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b1;

  logic [31:0] aAddr, aInstr, aPc4, aPerf;
  logic        aValid;
  logic [31:0] bAddr, bInstr, bPc4, bPerf;
  logic        bValid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dutA (
    .clk(clk), .reset(reset), .imem_addr(aAddr), .imem_data(aAddr),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(aValid),
    .out_ready(out_ready), .out_instr(aInstr), .out_pc4(aPc4), .perf_fetched(aPerf)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dutB (
    .clk(clk), .reset(reset), .imem_addr(bAddr), .imem_data(bAddr),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(bValid),
    .out_ready(out_ready), .out_instr(bInstr), .out_pc4(bPc4), .perf_fetched(bPerf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    total++; if (aValid !== 1'b0)     begin bad++; $display("FAIL rst_valid got=%0h exp=0", aValid); end
    total++; if (aAddr !== 32'h0)     begin bad++; $display("FAIL rst_addr got=%0h exp=0", aAddr); end
    total++; if (aInstr !== 32'h0)    begin bad++; $display("FAIL rst_instr got=%0h exp=0", aInstr); end
    total++; if (aPc4 !== 32'h0)      begin bad++; $display("FAIL rst_pc4 got=%0h exp=0", aPc4); end
    total++; if (aPerf !== 32'h0)     begin bad++; $display("FAIL rst_perf got=%0h exp=0", aPerf); end
    total++; if (bAddr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_addr_b got=%0h exp=fffffff8", bAddr); end
    reset = 1'b0;
    step(); // E0: BOOT->RUN, no fetch
    total++; if (aValid !== 1'b0)     begin bad++; $display("FAIL boot_valid got=%0h exp=0", aValid); end
    total++; if (aAddr !== 32'h0)     begin bad++; $display("FAIL boot_addr got=%0h exp=0", aAddr); end
    step(); // E1: first push
    total++; if (aValid !== 1'b1)     begin bad++; $display("FAIL first_valid got=%0h exp=1", aValid); end
    total++; if (aInstr !== 32'h0)    begin bad++; $display("FAIL first_instr got=%0h exp=0", aInstr); end
    total++; if (aPc4 !== 32'h4)      begin bad++; $display("FAIL first_pc4 got=%0h exp=4", aPc4); end
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (aValid !== 1'b1 || aInstr !== 32'(4*k) || aPc4 !== 32'(4*k+4)) begin
        bad++;
        $display("FAIL stream%0d got v=%0h i=%0h p=%0h exp v=1 i=%0h p=%0h",
                 k, aValid, aInstr, aPc4, 32'(4*k), 32'(4*k+4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (aAddr !== 32'h8 || aValid !== 1'b1 || aInstr !== 32'h0) begin
        bad++;
        $display("FAIL stall%0d got addr=%0h v=%0h i=%0h exp addr=8 v=1 i=0", k, aAddr, aValid, aInstr);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (aValid !== 1'b1 || aInstr !== 32'(4*k)) begin
        bad++;
        $display("FAIL drain%0d got v=%0h i=%0h exp v=1 i=%0h", k, aValid, aInstr, 32'(4*k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    step(); // two entries queued, pc=8
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    total++; if (aValid !== 1'b0)       begin bad++; $display("FAIL redir_valid got=%0h exp=0", aValid); end
    total++; if (aAddr !== 32'h100)     begin bad++; $display("FAIL redir_addr got=%0h exp=100", aAddr); end
    total++; if (aInstr !== 32'h0)      begin bad++; $display("FAIL redir_nop got=%0h exp=0", aInstr); end
    step();
    total++; if (aValid !== 1'b1)       begin bad++; $display("FAIL tgt_valid got=%0h exp=1", aValid); end
    total++; if (aInstr !== 32'h100)    begin bad++; $display("FAIL tgt_instr got=%0h exp=100", aInstr); end
    total++; if (aPc4 !== 32'h104)      begin bad++; $display("FAIL tgt_pc4 got=%0h exp=104", aPc4); end
    total++; if (aAddr !== 32'h104)     begin bad++; $display("FAIL tgt_addr got=%0h exp=104", aAddr); end
    out_ready = 1'b1;
  endtask

  task automatic test_redirect_boot();
    do_reset();
    out_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0042;
    step(); // E0 in BOOT
    redirect = 1'b0;
    total++; if (aAddr !== 32'h40 || aValid !== 1'b0) begin
      bad++; $display("FAIL boot_redir got addr=%0h v=%0h exp addr=40 v=0", aAddr, aValid);
    end
    step();
    total++; if (aValid !== 1'b1 || aInstr !== 32'h40 || aPc4 !== 32'h44) begin
      bad++; $display("FAIL boot_redir_tgt got v=%0h i=%0h p=%0h exp v=1 i=40 p=44", aValid, aInstr, aPc4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    step();
    total++; if (bAddr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_a0 got=%0h exp=fffffff8", bAddr); end
    step();
    total++; if (bInstr !== 32'hFFFF_FFF8 || bPc4 !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_e1 got i=%0h p=%0h exp i=fffffff8 p=fffffffc", bInstr, bPc4);
    end
    step();
    total++; if (bInstr !== 32'hFFFF_FFFC || bPc4 !== 32'h0 || bAddr !== 32'h0) begin
      bad++; $display("FAIL wrap_e2 got i=%0h p=%0h a=%0h exp i=fffffffc p=0 a=0", bInstr, bPc4, bAddr);
    end
    step();
    total++; if (bValid !== 1'b1 || bInstr !== 32'h0 || bPc4 !== 32'h4) begin
      bad++; $display("FAIL wrap_e3 got v=%0h i=%0h p=%0h exp v=1 i=0 p=4", bValid, bInstr, bPc4);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    total++; if (aAddr !== 32'h8) begin bad++; $display("FAIL full_addr got=%0h exp=8", aAddr); end
    reset = 1'b1;
    step();
    total++; if (aValid !== 1'b0 || aAddr !== 32'h0 || aPerf !== 32'h0) begin
      bad++; $display("FAIL midrst got v=%0h a=%0h perf=%0h exp v=0 a=0 perf=0", aValid, aAddr, aPerf);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (aValid !== 1'b0) begin bad++; $display("FAIL restart_boot got=%0h exp=0", aValid); end
    step();
    total++; if (aValid !== 1'b1 || aInstr !== 32'h0 || aPc4 !== 32'h4) begin
      bad++; $display("FAIL restart_first got v=%0h i=%0h p=%0h exp v=1 i=0 p=4", aValid, aInstr, aPc4);
    end
    step();
    total++; if (aInstr !== 32'h4 || aPc4 !== 32'h8) begin
      bad++; $display("FAIL restart_second got i=%0h p=%0h exp i=4 p=8", aInstr, aPc4);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp10, exp13;
    exp10 = PERF_ON ? 32'd10 : 32'd0;
    exp13 = PERF_ON ? 32'd13 : 32'd0;
    do_reset();
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 10; k++) step();
    total++; if (aPerf !== exp10) begin bad++; $display("FAIL perf10 got=%0d exp=%0d", aPerf, exp10); end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    total++; if (aPerf !== exp10) begin bad++; $display("FAIL perf_redir got=%0d exp=%0d", aPerf, exp10); end
    for (int k = 0; k < 3; k++) step();
    total++; if (aPerf !== exp13) begin bad++; $display("FAIL perf13 got=%0d exp=%0d", aPerf, exp13); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_boot();
    test_wrap();
    test_midreset();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
